// File: rtl/mux_sched_pkg.sv
// Shared constants for the 13-way round-robin mux scheduler: sizes, FSM state codes
// and the default idle select code.
package mux_sched_pkg;

    localparam int N_REQ = 13;
    localparam int SEL_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [SEL_W-1:0] SEL_IDLE_DEF = 4'hF;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/rr_pick13.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ... modulo 13.
// ptr must be in 0..12.
module rr_pick13
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // cand[gi] is the requester examined at scan position gi (gi=0 is highest priority)
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [SEL_W:0] sum;
        assign sum       = {1'b0, ptr} + 5'(gi + 1);
        assign cand[gi]  = (sum >= 5'(N_REQ)) ? SEL_W'(sum - 5'(N_REQ)) : sum[SEL_W-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx   = cand[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux13_scheduler.sv
// Round-robin scheduler sharing one 13-input mux; IDLE -> GRANT -> GAP -> (GRANT|IDLE).
// Optional grant timeout enabled by defining MUX_SCHED_TIMEOUT_EN.
module mux13_scheduler
    import mux_sched_pkg::*;
#(
    parameter int               MAX_HOLD = 16,
    parameter logic [SEL_W-1:0] SEL_IDLE = SEL_IDLE_DEF
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic             released
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be 1..255");
    end
    if (SEL_IDLE < 4'd13) begin : g_bad_sel_idle
        $error("SEL_IDLE must be 13..15");
    end

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             released_q, released_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             hold_expired;
    logic             grant_end;

    rr_pick13 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef MUX_SCHED_TIMEOUT_EN
    // hold_q counts GRANT cycles already completed for the current grant
    logic [7:0] hold_q, hold_d;

    assign hold_expired = (hold_q == 8'(MAX_HOLD - 1));

    always_comb begin
        hold_d = hold_q;
        if (state_q != ST_GRANT) begin
            hold_d = '0;
        end else if (!grant_end) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // While granting, sel_q holds the winner index
    assign grant_end = !req[sel_q] || hold_expired;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        released_d = 1'b0;
        ptr_d      = ptr_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (enable && pick_found) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    grant_d = idx_to_onehot(pick_idx);
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (grant_end) begin
                    state_d    = ST_GAP;
                    sel_d      = SEL_IDLE;
                    grant_d    = '0;
                    valid_d    = 1'b0;
                    released_d = 1'b1;
                    ptr_d      = sel_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_IDLE;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            released_q <= 1'b0;
            ptr_q      <= 4'd12;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            released_q <= released_d;
            ptr_q      <= ptr_d;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_valid = valid_q;
    assign released  = released_q;

endmodule

// File: tb/tb_mux13_scheduler.sv
// Self-checking bench for mux13_scheduler: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mux13_scheduler;

    localparam int MAX_HOLD = 4;
`ifdef MUX_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [12:0] req = '0;
    logic [3:0]  sel;
    logic [12:0] grant;
    logic        out_valid;
    logic        released;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: granted requester (-1 none), gap flag, pointer, grant age
    int m_gnt = -1;
    int m_gap = 0;
    int m_ptr = 12;
    int m_len = 0;
    bit model_on = 1'b0;

    mux13_scheduler #(.MAX_HOLD(MAX_HOLD), .SEL_IDLE(4'hF)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .released  (released)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic int winner(input logic [12:0] r, input int p);
        for (int k = 1; k <= 13; k++) begin
            int j;
            j = (p + k) % 13;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        logic [18:0] exp_v;
        logic [18:0] act_v;
        bit          started;
        started = 1'b0;
        if (!reset) begin
            m_gnt = -1; m_gap = 0; m_ptr = 12; m_len = 0; model_on = 1'b1;
        end else if (m_gnt >= 0) begin
            if (!req[m_gnt] || (TO_EN && m_len >= MAX_HOLD)) begin
                m_ptr = m_gnt; m_gnt = -1; m_gap = 1;
            end else begin
                m_len++;
            end
        end else begin
            m_gap = 0;
            if (enable && req != 0) begin
                m_gnt = winner(req, m_ptr); m_len = 1; started = 1'b1;
            end
        end
        #1;
        if (model_on) begin
            exp_v = {(m_gnt >= 0) ? 4'(m_gnt) : 4'hF,
                     (m_gnt >= 0) ? (13'd1 << m_gnt) : 13'd0,
                     (m_gnt >= 0), (m_gap != 0)};
            act_v = {sel, grant, out_valid, released};
            check("cycle", 32'(act_v), 32'(exp_v));
            if (started) $display("txn: grant to requester %0d (sel=%0d) at t=%0t", m_gnt, sel, $time);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset = 1'b0; req = '0; enable = 1'b1;
        tick(); tick();
        reset = 1'b1;
    endtask

    initial begin
        int order[$];
        int lens[$];
        int len;
        bit prev_valid;

        // Test 1: single request, release, gap, idle
        reset_dut();
        check("reset_state", {sel, grant, out_valid, released}, {4'hF, 13'd0, 1'b0, 1'b0});
        req = 13'h0001; tick();
        check("t1_grant", {sel, grant, out_valid}, {4'd0, 13'h0001, 1'b1});
        req = '0; tick();
        check("t1_gap", {sel, grant, out_valid, released}, {4'hF, 13'd0, 1'b0, 1'b1});
        tick();
        check("t1_idle", {out_valid, released}, {1'b0, 1'b0});

        // Test 2: all requesting, each held 3 cycles
        reset_dut();
        req = 13'h1FFF; prev_valid = 1'b0; len = 0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (out_valid && !prev_valid) begin order.push_back(int'(sel)); len = 0; end
            if (out_valid) len++;
            if (!out_valid && prev_valid) lens.push_back(len);
            prev_valid = out_valid;
            if (m_gnt >= 0 && m_len == 3) req[m_gnt] = 1'b0;
            if (req == 0 && !out_valid && !released) break;
        end
        check("t2_count", order.size(), 13);
        check("t2_lens", lens.size(), 13);
        for (int i = 0; i < 13; i++) begin
            if (i < order.size()) check("t2_order", order[i], i);
            if (i < lens.size()) check("t2_len", lens[i], 3);
        end

        // Test 3: pointer at 5 -> requester 0 beats 5, then 5
        reset_dut();
        req = 13'h0020; tick();
        check("t3_first5", sel, 4'd5);
        req = '0; tick(); tick();
        req = 13'h0021; tick();
        check("t3_zero_wins", sel, 4'd0);
        req = 13'h0020; tick();
        check("t3_gap", {sel, released}, {4'hF, 1'b1});
        tick();
        check("t3_five_next", {sel, out_valid}, {4'd5, 1'b1});
        req = '0; tick(); tick();

        // Test 4: enable gating
        reset_dut();
        enable = 1'b0; req = 13'h0100; tick(); tick();
        check("t4_blocked", {sel, out_valid}, {4'hF, 1'b0});
        enable = 1'b1; tick();
        check("t4_granted", {sel, grant}, {4'd8, 13'h0100});
        enable = 1'b0; tick(); tick();
        check("t4_hold", {sel, out_valid}, {4'd8, 1'b1});
        req = '0; tick(); tick(); enable = 1'b1;

        // Test 5: reset during grant of 7
        reset_dut();
        req = 13'h0080; tick();
        check("t5_grant7", sel, 4'd7);
        reset = 1'b0; tick();
        check("t5_reset", {sel, grant, released}, {4'hF, 13'd0, 1'b0});
        reset = 1'b1; req = 13'h0081; tick();
        check("t5_zero", sel, 4'd0);
        req = '0; tick(); tick();

`ifdef MUX_SCHED_TIMEOUT_EN
        // Test 6: timeout revokes a held grant after MAX_HOLD cycles
        reset_dut();
        req = 13'h0008;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_hold", {sel, out_valid}, {4'd3, 1'b1});
        end
        tick();
        check("t6_gap", {out_valid, released}, {1'b0, 1'b1});
        tick();
        check("t6_regrant", {sel, out_valid}, {4'd3, 1'b1});
        req = '0; tick(); tick();
`endif

        // Randomized traffic against the model
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset  = ($urandom_range(99) != 0);
            enable = ($urandom_range(9) != 0);
            req    = req ^ 13'($urandom & $urandom & $urandom);
        end
        reset = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
